// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle between N requesters, the write arbiter and the FIFO write port.
// master drives requests/data/full; slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned WL = 8
);
  logic [N-1:0]    req;
  logic [N*WL-1:0] din;
  logic            fifo_full;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            fifo_wReq;
  logic [WL-1:0]   fifo_din;
  logic            busy;

  modport master (
    output req, din, fifo_full,
    input  gnt, ack, fifo_wReq, fifo_din, busy
  );

  modport slave (
    input  req, din, fifo_full,
    output gnt, ack, fifo_wReq, fifo_din, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter feeding a synchronous FIFO write port.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating full-stall cycle counter.
module fifo_wr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WL    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef FIFO_ARB_STALL_CNT_EN
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt,
`endif
  fifo_wr_arbiter_if.slave  bus
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CountLast = CW'(BURST - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] last_q, last_d;

  logic [N-1:0]  ack;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          accepted;
  logic          req_owner;
  logic [WL-1:0] fifo_din_c;

  assign ack       = gnt_q & bus.req & {N{~bus.fifo_full}};
  assign accepted  = |ack;
  assign req_owner = |(gnt_q & bus.req);

  always_comb begin
    owner = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) owner = IW'(i);
    end
  end

  // Scan starts just after the last owner so it becomes lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && bus.req[(int'(last_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(last_q) + k) % N);
      end
    end
  end

  always_comb begin
    fifo_din_c = '0;
    for (int i = 0; i < N; i++) begin
      fifo_din_c = fifo_din_c | (bus.din[i*WL +: WL] & {WL{gnt_q[i]}});
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    count_d = count_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          count_d         = '0;
          state_d         = GRANT;
        end
      end
      GRANT: begin
        if ((accepted && count_q == CountLast) || !req_owner) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner;
          count_d = '0;
        end else if (accepted) begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      count_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack;
  assign bus.fifo_wReq = accepted;
  assign bus.fifo_din  = fifo_din_c;
  assign bus.busy      = (state_q == GRANT);

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_q <= '0;
    end else if (stall_clr) begin
      stall_q <= '0;
    end else if (state_q == GRANT && req_owner && bus.fifo_full && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter (N=4, WL=8, BURST=4) plus hand-written
// full-stall and optional stall-counter sequences.
module tb_fifo_wr_arbiter;
  localparam int unsigned N     = 4;
  localparam int unsigned WL    = 8;
  localparam int unsigned BURST = 4;

  logic clk;
  logic rst;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic        stall_clr;
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter_if #(.N(N), .WL(WL)) bus_if ();

  fifo_wr_arbiter #(.N(N), .WL(WL), .BURST(BURST)) dut (
    .CLK       (clk),
    .RST       (rst),
`ifdef FIFO_ARB_STALL_CNT_EN
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        wreq;
    logic [7:0]  fdin;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] D = 32'h33221100;

  task automatic add(input logic r, input logic [3:0] rq, input logic f, input logic [31:0] d,
                     input logic [3:0] g, input logic [3:0] a, input logic w,
                     input logic [7:0] fd, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.din = d;
    v.gnt = g; v.ack = a; v.wreq = w; v.fdin = fd; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, bus_if.gnt, bus_if.ack, bus_if.fifo_wReq, bus_if.fifo_din, bus_if.busy};
  endfunction

  // Inputs are applied 1 time unit after posedge; outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus_if.req = '0;
    bus_if.din = '0;
    bus_if.fifo_full = 1'b0;
`ifdef FIFO_ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif

    // Single requester 0: burst A0..A3, bubble, re-grant A4, A5, then drop.
    add(1, 4'b0000, 0, 32'h0,  4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0001, 0, 32'hA0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0001, 0, 32'hA0, 4'b0001, 4'b0001, 1, 8'hA0, 1);
    add(1, 4'b0001, 0, 32'hA1, 4'b0001, 4'b0001, 1, 8'hA1, 1);
    add(1, 4'b0001, 0, 32'hA2, 4'b0001, 4'b0001, 1, 8'hA2, 1);
    add(1, 4'b0001, 0, 32'hA3, 4'b0001, 4'b0001, 1, 8'hA3, 1);
    add(1, 4'b0001, 0, 32'hA4, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b0001, 0, 32'hA4, 4'b0001, 4'b0001, 1, 8'hA4, 1);
    add(1, 4'b0001, 0, 32'hA5, 4'b0001, 4'b0001, 1, 8'hA5, 1);
    add(1, 4'b0000, 0, 32'hA5, 4'b0001, 4'b0000, 0, 8'hA5, 1);
    add(1, 4'b0000, 0, 32'hA5, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // Reset restores last=N-1, then all four request: order 0,1,2,3,0.
    add(0, 4'b1111, 0, D, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, 0, D, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int o = 0; o < 4; o++) begin
      for (int w = 0; w < 4; w++)
        add(1, 4'b1111, 0, D, 4'(1 << o), 4'(1 << o), 1, 8'(o * 8'h11), 1);
      add(1, 4'b1111, 0, D, 4'b0000, 4'b0000, 0, 8'h00, 0);
    end
    // Owner 0 again: 2 accepts, 3 full cycles, 2 more accepts.
    add(1, 4'b1111, 0, D, 4'b0001, 4'b0001, 1, 8'h00, 1);
    add(1, 4'b1111, 0, D, 4'b0001, 4'b0001, 1, 8'h00, 1);
    for (int s = 0; s < 3; s++)
      add(1, 4'b1111, 1, D, 4'b0001, 4'b0000, 0, 8'h00, 1);
    add(1, 4'b1111, 0, D, 4'b0001, 4'b0001, 1, 8'h00, 1);
    add(1, 4'b1111, 0, D, 4'b0001, 4'b0001, 1, 8'h00, 1);
    add(1, 4'b1111, 0, D, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // Owner 1 drops after one accept; requester 2 takes over.
    add(1, 4'b1111, 0, D, 4'b0010, 4'b0010, 1, 8'h11, 1);
    add(1, 4'b1101, 0, D, 4'b0010, 4'b0000, 0, 8'h11, 1);
    add(1, 4'b1101, 0, D, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1101, 0, D, 4'b0100, 4'b0100, 1, 8'h22, 1);
    add(1, 4'b1111, 0, D, 4'b0100, 4'b0100, 1, 8'h22, 1);
    // Reset with count=2 aborts the burst; requester 0 wins afterwards.
    add(0, 4'b1111, 0, D, 4'b0100, 4'b0100, 1, 8'h22, 1);
    add(1, 4'b1111, 0, D, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, 0, D, 4'b0001, 4'b0001, 1, 8'h00, 1);

    step();
    step();
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      bus_if.req = vecs[i].req;
      bus_if.fifo_full = vecs[i].full;
      bus_if.din = vecs[i].din;
      #4;
      checks++;
      if (outs() !== {14'd0, vecs[i].gnt, vecs[i].ack, vecs[i].wreq, vecs[i].fdin, vecs[i].busy})
      begin
        errors++;
        $display("FAIL vec%0d: got gnt=%b ack=%b wreq=%b fdin=%h busy=%b expected gnt=%b ack=%b wreq=%b fdin=%h busy=%b",
                 i, bus_if.gnt, bus_if.ack, bus_if.fifo_wReq, bus_if.fifo_din, bus_if.busy,
                 vecs[i].gnt, vecs[i].ack, vecs[i].wreq, vecs[i].fdin, vecs[i].busy);
      end
      step();
    end

    // Long full stall keeps the grant with no timeout and no write request.
    bus_if.req = 4'b1111;
    bus_if.fifo_full = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #4;
      check("stall_gnt", 32'(bus_if.gnt), 32'h1);
      check("stall_wreq", 32'(bus_if.fifo_wReq), 32'h0);
      step();
    end
    bus_if.req = 4'b0000;
    bus_if.fifo_full = 1'b0;
    #4;
    check("drop_ack", 32'(bus_if.ack), 32'h0);
    step();
    #4;
    check("drop_release", {bus_if.gnt, 3'b0, bus_if.busy}, 32'h0);
    step();

`ifdef FIFO_ARB_STALL_CNT_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    #4;
    check("stall_cnt_rst", 32'(stall_cnt), 32'h0);
    bus_if.req = 4'b0001;
    bus_if.fifo_full = 1'b1;
    step();
    for (int s = 0; s < 5; s++) step();
    #4;
    check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    check("stall_gnt_held", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0000;
    bus_if.fifo_full = 1'b0;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    #4;
    check("stall_cnt_clr", 32'(stall_cnt), 32'h0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets N producers share the single write port of the team's synchronous FIFO buffer (WL-bit data, Full/Empty/Error flags).
- Grants one producer at a time for a burst of up to BURST words, stalls on FIFO Full, and drives the FIFO's wReq/din.
- The FIFO read side is untouched; this block sits between the producers and the FIFO write port.

Parameters:
- N, 4: number of requesters; legal range 2..16.
- WL, 8: data word width; must equal the FIFO WL.
- BURST, 4: maximum words accepted per grant; must be >= 1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- req  in  N  per-requester request; the requester holds it high while its din slice is valid.
- din  in  N*WL  packed requester data; requester i uses bits [i*WL +: WL].
- fifo_full  in  1  FIFO Full flag.
- gnt  out  N  one-hot grant, registered; all zero when idle.
- ack  out  N  one-hot word-accepted strobe, combinational; ack[i] = gnt[i] & req[i] & ~fifo_full.
- fifo_wReq  out  1  FIFO write request; equals |ack.
- fifo_din  out  WL  din slice of the granted requester; 0 when no grant is held.
- busy  out  1  high while in state GRANT.

Behaviour:
- Reset (RST=0 at a clock edge), taking effect from the next cycle:
  - gnt=0, count=0, state=IDLE, last=N-1 (so requester 0 wins first).
  - Derived outputs therefore read ack=0, fifo_wReq=0, fifo_din=0, busy=0.
  - Reset mid-burst aborts the burst immediately; no partial-burst state is retained.
- FSM state IDLE:
  - If |req, pick the first set req[i] scanning last+1, last+2, ... mod N.
  - Register gnt=onehot(i), count=0, and go to GRANT.
  - Otherwise stay in IDLE.
- FSM state GRANT (owner = index of the set gnt bit):
  - A word is accepted when ack[owner]=1. That cycle fifo_wReq=1, fifo_din=din[owner], and count increments.
  - Release condition: (accepted and count==BURST-1) or req[owner]=0.
  - On release the next state is IDLE, gnt=0, last=owner, count=0.
  - fifo_full=1 holds the grant with no accept and no count change; there is no timeout.
- Latency:
  - req to first possible accept is 2 cycles: IDLE decision, then GRANT.
  - Switching owner costs one bubble cycle spent in IDLE.
- Throughput: 1 word per cycle within a burst while the FIFO is not full.
- Fairness: an owner holding req continuously for more than BURST words is released after BURST accepts and moves to lowest priority.
- Req timing:
  - Req is sampled only as described above.
  - A requester dropping req while granted loses the grant next cycle, with no accept in the drop cycle.
- Safety: fifo_wReq is never asserted while fifo_full=1, so FIFO Error can only come from the read side.
- Width: count is $clog2(BURST+1) bits; the round-robin index is $clog2(N) bits and wraps N-1 to 0.

Optional Feature:
- Macro: FIFO_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (16 bits).
  - Counts cycles with state=GRANT, req[owner]=1 and fifo_full=1.
  - Saturates at 16'hFFFF and clears on reset.
  - Adds input stall_clr (1 bit), which zeroes the counter next cycle and takes priority over the increment.
- When undefined: neither port exists, no counter logic is built, and all other behaviour is identical.

Test Plan:
- Single requester, N=4, BURST=4: req=4'b0001 held, din[0]=8'hA0..A5, fifo_full=0.
  - gnt=0001 one cycle after req.
  - Accepts A0..A3, then 1 IDLE cycle, then re-grant to 0 and A4, A5 accepted.
- All four req high continuously:
  - Grant order 0,1,2,3,0.
  - Each owner gets exactly 4 fifo_wReq pulses; exactly 1 idle cycle between grants.
- fifo_full forced to 1 for 3 cycles mid-burst after 2 accepts:
  - fifo_wReq=0 and ack=0 for those 3 cycles; gnt held.
  - Remaining 2 words accepted after Full deasserts.
- Owner drops req after 1 accept while requester 2 is waiting:
  - Grant releases next cycle; gnt=0100 one cycle later.
- RST=0 asserted during a burst with count=2:
  - Next cycle gnt=0, fifo_wReq=0, busy=0.
  - First grant after release goes to requester 0 when all req are high.
- With FIFO_ARB_STALL_CNT_EN, Full held 5 cycles under grant:
  - stall_cnt=5.
  - stall_clr pulse gives stall_cnt=0 next cycle.
